scroll_framebuffer: RTL and testbench

- Pixel store on the responder end of the plot-write interface (x, y, colour, plot) that scrolling and drawing blocks drive.
- Accepts single-pixel writes into a 160x120 on-chip buffer.
- Serves a pipelined scanout read port that applies a vertical scroll offset with wrap-around.
- Provides a hardware clear sequence, so drawing logic never needs to sweep the screen itself.

---
 rtl/scroll_framebuffer.sv | 160 ++++++++++++++++
 tb/tb_scroll_framebuffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_framebuffer.sv
// scroll_framebuffer
//   160x120 pixel store written through the plot interface and read by a
//   two-stage scanout port that applies a vertical scroll offset with wrap.
//   A hardware clear sweeps CLEAR_COLOUR over every pixel, one per cycle.
//
// Ports
//   clock, resetn          system clock, asynchronous active-low reset
//   x, y, colour, plot     single-pixel write request (physical coordinates)
//   ready                  write accepted this cycle (low while clearing)
//   clear / busy           start full-buffer clear / clear in progress
//   scroll_offset/_load    load a new vertical offset (>= YSCREEN loads 0)
//   rd_en, rd_x, rd_y      scanout read request (display row)
//   rd_colour, rd_valid    read data, valid two cycles after rd_en
module scroll_framebuffer #(
    parameter int                  XSCREEN      = 160,
    parameter int                  YSCREEN      = 120,
    parameter int                  COLOUR_W     = 3,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [7:0]          x,
    input  logic [6:0]          y,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                plot,
    output logic                ready,
    input  logic                clear,
    output logic                busy,
    input  logic [6:0]          scroll_offset,
    input  logic                scroll_load,
    input  logic                rd_en,
    input  logic [7:0]          rd_x,
    input  logic [6:0]          rd_y,
    output logic [COLOUR_W-1:0] rd_colour,
    output logic                rd_valid
);

    localparam int                NPIX      = XSCREEN * YSCREEN;
    localparam int                ADDR_W    = $clog2(NPIX);
    localparam logic [7:0]        XS        = 8'(XSCREEN);
    localparam logic [6:0]        YS        = 7'(YSCREEN);
    localparam logic [ADDR_W-1:0] XS_A      = ADDR_W'(XSCREEN);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic                w_clr_last;
    logic [6:0]          r_offset;

    // ---------------- clear FSM ----------------
    assign w_clr_last = (r_clr_addr == LAST_ADDR);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // clear while already sweeping is ignored: no restart
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (clear)      w_state_nxt = S_CLEAR;
            S_CLEAR: if (w_clr_last) w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (r_state == S_IDLE);
        busy  = (r_state == S_CLEAR);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_clr_addr <= '0;
        else if (r_state == S_CLEAR)
            r_clr_addr <= w_clr_last ? '0 : r_clr_addr + ADDR_W'(1);
    end

    // ---------------- scroll offset ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)          r_offset <= '0;
        else if (scroll_load) r_offset <= (scroll_offset < YS) ? scroll_offset : '0;
    end

    // ---------------- write port ----------------
    logic                w_wr_inrange, w_we;
    logic [ADDR_W-1:0]   w_wr_addr, w_waddr;
    logic [COLOUR_W-1:0] w_wdata;

    assign w_wr_inrange = (x < XS) && (y < YS);
    assign w_wr_addr    = ADDR_W'(y) * XS_A + ADDR_W'(x);
    // the clear sweep owns the write port; user plots are refused via ready
    assign w_we         = busy || (plot && ready && w_wr_inrange);
    assign w_waddr      = busy ? r_clr_addr   : w_wr_addr;
    assign w_wdata      = busy ? CLEAR_COLOUR : colour;

    logic [COLOUR_W-1:0] r_mem [0:NPIX-1];

    always_ff @(posedge clock) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    // ---------------- read stage 1: scroll + address ----------------
    logic [7:0]        w_row_sum;
    logic [6:0]        w_phys_row;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_oob;
    logic              r_s1_vld, r_s1_oob;
    logic [ADDR_W-1:0] r_s1_addr;

    // both operands are below YSCREEN, so one conditional subtract wraps
    assign w_row_sum  = {1'b0, rd_y} + {1'b0, r_offset};
    assign w_phys_row = (w_row_sum >= {1'b0, YS}) ? 7'(w_row_sum - {1'b0, YS})
                                                  : w_row_sum[6:0];
    assign w_rd_addr  = ADDR_W'(w_phys_row) * XS_A + ADDR_W'(rd_x);
    assign w_rd_oob   = (rd_x >= XS) || (rd_y >= YS);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_s1_vld  <= 1'b0;
            r_s1_oob  <= 1'b1;
            r_s1_addr <= '0;
        end else begin
            r_s1_vld <= rd_en;
            if (rd_en) begin
                r_s1_oob  <= w_rd_oob;
                // keep the RAM address in range for off-screen requests
                r_s1_addr <= w_rd_oob ? '0 : w_rd_addr;
            end
        end
    end

    // ---------------- read stage 2: RAM data ----------------
    // The RAM output register has no reset so it maps onto block RAM; the
    // reset-able blank flag forces CLEAR_COLOUR out of reset and for
    // off-screen reads. Both only update on a valid read, so rd_colour holds.
    logic [COLOUR_W-1:0] r_mem_q;
    logic                r_s2_vld, r_s2_blank;

    always_ff @(posedge clock) begin
        if (r_s1_vld) r_mem_q <= r_mem[r_s1_addr];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_s2_vld   <= 1'b0;
            r_s2_blank <= 1'b1;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) r_s2_blank <= r_s1_oob;
        end
    end

    assign rd_colour = r_s2_blank ? CLEAR_COLOUR : r_mem_q;
    assign rd_valid  = r_s2_vld;

endmodule

// File: tb/tb_scroll_framebuffer.sv
// Bench for scroll_framebuffer: a pixel-array model predicts ready, busy,
// rd_valid and rd_colour every cycle; directed reads pin literal values.
module tb_scroll_framebuffer;

    localparam int XS   = 160;
    localparam int YS   = 120;
    localparam int NPIX = XS * YS;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] colour = '0;
    logic       plot = 1'b0;
    logic       ready;
    logic       clear = 1'b0;
    logic       busy;
    logic [6:0] scroll_offset = '0;
    logic       scroll_load = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_x = '0;
    logic [6:0] rd_y = '0;
    logic [2:0] rd_colour;
    logic       rd_valid;

    always #10 clock = ~clock;

    scroll_framebuffer dut (
        .clock(clock), .resetn(resetn),
        .x(x), .y(y), .colour(colour), .plot(plot), .ready(ready),
        .clear(clear), .busy(busy),
        .scroll_offset(scroll_offset), .scroll_load(scroll_load),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
        .rd_colour(rd_colour), .rd_valid(rd_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0] m_mem [NPIX];
    bit         m_clearing = 0;
    int         m_clr = 0;
    int         m_off = 0;
    bit         p_vld = 0, p_oob = 0;    // read issued at the previous edge
    int         p_addr = 0;
    bit         e_vld = 0;
    logic [2:0] e_col = '0;

    initial for (int i = 0; i < NPIX; i++) m_mem[i] = '0;

    always @(posedge clock) begin
        if (!resetn) begin
            m_clearing = 0; m_clr = 0; m_off = 0;
            p_vld = 0; e_vld = 0; e_col = '0;
        end else begin
            // a read sees memory as it was before this edge's write
            e_vld = p_vld;
            if (p_vld) e_col = p_oob ? 3'b000 : m_mem[p_addr];
            p_vld = rd_en;
            if (rd_en) begin
                p_oob  = (rd_x >= XS) || (rd_y >= YS);
                p_addr = p_oob ? 0 : ((int'(rd_y) + m_off) % YS) * XS + int'(rd_x);
            end
            if (m_clearing) begin
                m_mem[m_clr] = '0;
                m_clr++;
                if (m_clr == NPIX) begin m_clearing = 0; m_clr = 0; end
            end else begin
                if (plot && x < XS && y < YS) m_mem[int'(y) * XS + int'(x)] = colour;
                if (clear) m_clearing = 1;
            end
            if (scroll_load) m_off = (scroll_offset < YS) ? int'(scroll_offset) : 0;
        end
    end

    always @(negedge clock) begin
        check("ready",     ready,     32'(!m_clearing));
        check("busy",      busy,      32'(m_clearing));
        check("rd_valid",  rd_valid,  32'(e_vld));
        check("rd_colour", rd_colour, 32'(e_col));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] wx, input logic [6:0] wy, input logic [2:0] c);
        plot = 1; x = wx; y = wy; colour = c;
        tick();
        plot = 0;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] rx, input logic [6:0] ry,
                          input logic [2:0] exp);
        rd_en = 1; rd_x = rx; rd_y = ry;
        tick();
        rd_en = 0;
        tick();
        check({nm, "_valid"}, rd_valid, 1);
        check(nm, rd_colour, exp);
        check({nm, "_model"}, e_col, exp);
    endtask

    task automatic load_off(input logic [6:0] o);
        scroll_load = 1; scroll_offset = o;
        tick();
        scroll_load = 0;
    endtask

    // counts busy cycles; optional random plots and ignored clear pulses
    task automatic wait_clear(input bit noise, output int n);
        n = 0;
        while (busy && n < 25000) begin
            if (noise) begin
                plot = 1; x = 8'($urandom_range(0, 159)); y = 7'($urandom_range(0, 119));
                colour = 3'($urandom_range(1, 7)); clear = ($urandom % 64) == 0;
            end
            tick();
            n++;
        end
        plot = 0; clear = 0;
        if (n >= 25000) check("clear_timeout", n, 0);
    endtask

    int n, nz;

    initial begin
        repeat (3) tick();
        resetn = 1;
        tick();
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_colour", rd_colour, 0);

        // initial clear gives the RAM a known content
        clear = 1; tick(); clear = 0;
        wait_clear(0, n);
        check("init_clear_len", n, NPIX);

        // basic write / read
        wr(5, 10, 3'b101);
        rd_chk("basic", 5, 10, 3'b101);

        // scroll offset and wrap
        load_off(20);
        wr(0, 25, 3'b011);
        rd_chk("scroll20", 0, 5, 3'b011);
        wr(7, 3, 3'b110);
        rd_chk("wrap103", 7, 103, 3'b110);
        load_off(120);
        check("model_off120", m_off, 0);
        rd_chk("off120", 0, 25, 3'b011);

        // out-of-range writes and reads
        wr(0, 1, 3'b101);
        wr(40, 1, 3'b111);
        wr(160, 0, 3'b111);
        wr(0, 120, 3'b111);
        rd_chk("oob_wx_neighbour", 0, 1, 3'b101);
        rd_chk("oob_wy_neighbour", 0, 119, 3'b000);
        rd_chk("oob_rdx200", 200, 0, 3'b000);
        rd_chk("oob_rdy120", 0, 120, 3'b000);

        // same-address write on the RAM read edge: old data, then new
        wr(9, 9, 3'b001);
        rd_en = 1; rd_x = 9; rd_y = 9;
        tick();
        plot = 1; x = 9; y = 9; colour = 3'b110;
        tick();
        plot = 0; rd_en = 0;
        check("rbw_old", rd_colour, 3'b001);
        tick();
        check("rbw_new", rd_colour, 3'b110);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            plot = $urandom % 2;
            x = 8'($urandom_range(0, 169)); y = 7'($urandom_range(0, 124));
            colour = 3'($urandom);
            rd_en = $urandom % 2;
            rd_x = 8'($urandom_range(0, 165)); rd_y = 7'($urandom_range(0, 124));
            scroll_load = ($urandom % 16) == 0;
            scroll_offset = 7'($urandom_range(0, 127));
            tick();
        end
        plot = 0; rd_en = 0; scroll_load = 0;
        tick(); tick();

        // full clear with plots and clear pulses during the sweep
        clear = 1; tick(); clear = 0;
        check("clear_busy", busy, 1);
        check("clear_ready", ready, 0);
        wait_clear(1, n);
        check("clear_len", n, NPIX);
        nz = 0;
        for (int a = 0; a < NPIX; a++) begin
            rd_en = 1; rd_x = 8'(a % XS); rd_y = 7'(a / XS);
            tick();
            if (rd_valid && rd_colour != 0) nz++;
        end
        rd_en = 0;
        tick();
        if (rd_valid && rd_colour != 0) nz++;
        tick();
        if (rd_valid && rd_colour != 0) nz++;
        check("sweep_all_zero", nz, 0);

        // reset at cycle 5000 of a clear
        wr(39, 31, 3'b111);   // address 4999
        wr(40, 31, 3'b101);   // address 5000
        clear = 1; tick(); clear = 0;
        repeat (4997) tick();
        rd_en = 1; rd_x = 0; rd_y = 0;
        repeat (3) tick();
        check("pre_rst_valid", rd_valid, 1);
        resetn = 0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 1);
        check("abort_rd_valid", rd_valid, 0);
        rd_en = 0;
        tick();
        resetn = 1;
        tick();
        rd_chk("abort_addr4999", 39, 31, 3'b000);
        rd_chk("abort_addr5000", 40, 31, 3'b101);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
